// File: rtl/seg7_scan_decoder_if.sv
// Bus between a multiplexed 4-digit 7-segment display driver and its
// receive-side decoder. The driver side (master) produces the scanned
// an_n/seg_n lines; the decoder side (slave) returns the rebuilt value.
interface seg7_scan_decoder_if;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic [3:0] digit_u;
  logic [3:0] digit_d;
  logic [6:0] value;
  logic       frame_valid;
  logic       seg_err;
  logic       no_signal;

  // Handshake: there is no back-pressure. frame_valid is a one-cycle strobe
  // meaning digit_u/digit_d/value were updated on this cycle; a consumer must
  // sample them while frame_valid is high or rely on them holding until the
  // next strobe. seg_err is an independent one-cycle strobe; no_signal is a level.
  modport master (
    output an_n, seg_n,
    input  digit_u, digit_d, value, frame_valid, seg_err, no_signal
  );

  modport slave (
    input  an_n, seg_n,
    output digit_u, digit_d, value, frame_valid, seg_err, no_signal
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment bus. Synchronizes the
// active-low enables/segments, waits for each pattern to settle, decodes the
// units and tens digits and reports the rebuilt 0..99 value once per frame.
module seg7_scan_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_decoder_if.slave bus,
  output logic [1:0]         dbg_state
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SETTLE_PRE = SW'(SETTLE_CYC - 2);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_PRE     = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Returns {legal, digit}. Blank (all segments off) is a legal 0 so that a
  // leading-blank tens digit still completes a frame.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'd0};
      7'h06:   r = {1'b1, 4'd1};
      7'h5B:   r = {1'b1, 4'd2};
      7'h4F:   r = {1'b1, 4'd3};
      7'h66:   r = {1'b1, 4'd4};
      7'h6D:   r = {1'b1, 4'd5};
      7'h7D:   r = {1'b1, 4'd6};
      7'h07:   r = {1'b1, 4'd7};
      7'h7F:   r = {1'b1, 4'd8};
      7'h6F:   r = {1'b1, 4'd9};
      7'h00:   r = {1'b1, 4'd0};
      default: r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Input synchronizers. Reset to the idle bus (no digit enabled, blank).
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][3:0] an_sync;
  logic [SYNC_STAGES-1:0][6:0] segn_sync;

  // Shift the raw bus through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_sync   <= '1;
      segn_sync <= '1;
    end else begin
      an_sync   <= {an_sync[SYNC_STAGES-2:0], bus.an_n};
      segn_sync <= {segn_sync[SYNC_STAGES-2:0], bus.seg_n};
    end
  end

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic [10:0] pat_cur;
  logic [10:0] pat_prev;
  logic        pat_same;

  assign an_s     = an_sync[SYNC_STAGES-1];
  assign seg_s    = ~segn_sync[SYNC_STAGES-1];
  assign pat_cur  = {an_s, seg_s};
  assign pat_same = (pat_cur == pat_prev);

  // ---------------------------------------------------------------------
  // Settle counter: restarts on any change, saturates so each dwell can
  // produce at most one capture.
  // ---------------------------------------------------------------------
  logic [SW-1:0] settle_cnt;

  // Track the previous synced pattern and how long it has been stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_prev   <= {4'hF, 7'h00};
      settle_cnt <= '0;
    end else begin
      pat_prev <= pat_cur;
      if (!pat_same) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  // A capture fires on the edge where the counter reaches its ceiling, and
  // only for a lone units or tens enable with hundreds/thousands off.
  logic       slot_ok;
  logic       cap_v;
  logic       cap_tens;
  logic [4:0] cap_dec;

  assign slot_ok  = (an_s[3:2] == 2'b11) && (an_s[1] != an_s[0]);
  assign cap_v    = pat_same && (settle_cnt == SETTLE_PRE) && slot_ok;
  assign cap_tens = ~an_s[1];
  assign cap_dec  = decode_seg(seg_s);

  // ---------------------------------------------------------------------
  // Frame assembly FSM
  // ---------------------------------------------------------------------
  state_t        state, state_nxt;
  logic          flag_u, flag_u_nxt;
  logic          flag_d, flag_d_nxt;
  logic [3:0]    slot_u, slot_u_nxt;
  logic [3:0]    slot_d, slot_d_nxt;
  logic          pend_v, pend_v_nxt;
  logic          pend_tens, pend_tens_nxt;
  logic [4:0]    pend_dec, pend_dec_nxt;
  logic [3:0]    digit_u_q, digit_u_nxt;
  logic [3:0]    digit_d_q, digit_d_nxt;
  logic [6:0]    value_q, value_nxt;
  logic          frame_valid_q, frame_valid_nxt;
  logic          seg_err_q, seg_err_nxt;
  logic          no_signal_q, no_signal_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;

  logic          apply_v;
  logic          apply_tens;
  logic [4:0]    apply_dec;
  logic          complete;
  logic [3:0]    new_u;
  logic [3:0]    new_d;
  logic          to_expire;

  // Register all FSM, slot, timeout and output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      flag_u        <= 1'b0;
      flag_d        <= 1'b0;
      slot_u        <= '0;
      slot_d        <= '0;
      pend_v        <= 1'b0;
      pend_tens     <= 1'b0;
      pend_dec      <= '0;
      digit_u_q     <= '0;
      digit_d_q     <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      no_signal_q   <= 1'b0;
      to_cnt        <= '0;
    end else begin
      state         <= state_nxt;
      flag_u        <= flag_u_nxt;
      flag_d        <= flag_d_nxt;
      slot_u        <= slot_u_nxt;
      slot_d        <= slot_d_nxt;
      pend_v        <= pend_v_nxt;
      pend_tens     <= pend_tens_nxt;
      pend_dec      <= pend_dec_nxt;
      digit_u_q     <= digit_u_nxt;
      digit_d_q     <= digit_d_nxt;
      value_q       <= value_nxt;
      frame_valid_q <= frame_valid_nxt;
      seg_err_q     <= seg_err_nxt;
      no_signal_q   <= no_signal_nxt;
      to_cnt        <= to_cnt_nxt;
    end
  end

  // Next-state: apply captures to slots, emit frames, handle timeout.
  always_comb begin
    state_nxt       = state;
    flag_u_nxt      = flag_u;
    flag_d_nxt      = flag_d;
    slot_u_nxt      = slot_u;
    slot_d_nxt      = slot_d;
    pend_v_nxt      = 1'b0;
    pend_tens_nxt   = pend_tens;
    pend_dec_nxt    = pend_dec;
    digit_u_nxt     = digit_u_q;
    digit_d_nxt     = digit_d_q;
    value_nxt       = value_q;
    frame_valid_nxt = 1'b0;
    seg_err_nxt     = 1'b0;
    no_signal_nxt   = no_signal_q;
    to_cnt_nxt      = to_cnt;
    apply_v         = 1'b0;
    apply_tens      = 1'b0;
    apply_dec       = '0;
    complete        = 1'b0;
    new_u           = slot_u;
    new_d           = slot_d;
    to_expire       = 1'b0;

    // A parked capture goes first; a live capture is used when not emitting.
    if (pend_v) begin
      apply_v    = 1'b1;
      apply_tens = pend_tens;
      apply_dec  = pend_dec;
    end else if (cap_v && (state != EMIT)) begin
      apply_v    = 1'b1;
      apply_tens = cap_tens;
      apply_dec  = cap_dec;
    end

    // Captures that cannot be applied this cycle are parked, never dropped.
    if (cap_v && ((state == EMIT) || pend_v)) begin
      pend_v_nxt    = 1'b1;
      pend_tens_nxt = cap_tens;
      pend_dec_nxt  = cap_dec;
    end

    // Any capture, legal or not, proves the bus is alive.
    if (cap_v) begin
      to_cnt_nxt = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_nxt = to_cnt + 1'b1;
    end
    to_expire = !cap_v && !pend_v && (to_cnt == TO_PRE);

    case (state)
      IDLE, COLLECT: begin
        if (apply_v) begin
          if (!apply_dec[4]) begin
            seg_err_nxt = 1'b1;
            flag_u_nxt  = 1'b0;
            flag_d_nxt  = 1'b0;
          end else begin
            no_signal_nxt = 1'b0;
            state_nxt     = COLLECT;
            if (apply_tens) begin
              slot_d_nxt = apply_dec[3:0];
              flag_d_nxt = 1'b1;
              new_d      = apply_dec[3:0];
              complete   = flag_u;
            end else begin
              slot_u_nxt = apply_dec[3:0];
              flag_u_nxt = 1'b1;
              new_u      = apply_dec[3:0];
              complete   = flag_d;
            end
            if (complete) begin
              digit_u_nxt     = new_u;
              digit_d_nxt     = new_d;
              value_nxt       = {new_d, 3'b000} + {2'b00, new_d, 1'b0} + {3'b000, new_u};
              frame_valid_nxt = 1'b1;
              state_nxt       = EMIT;
            end
          end
        end
      end
      EMIT: begin
        flag_u_nxt = 1'b0;
        flag_d_nxt = 1'b0;
        state_nxt  = COLLECT;
      end
      default: begin
        flag_u_nxt = 1'b0;
        flag_d_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase

    // Silence on the bus drops back to IDLE; the last frame stays visible.
    if (to_expire) begin
      no_signal_nxt = 1'b1;
      state_nxt     = IDLE;
      flag_u_nxt    = 1'b0;
      flag_d_nxt    = 1'b0;
    end
  end

  assign bus.digit_u     = digit_u_q;
  assign bus.digit_d     = digit_d_q;
  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.no_signal   = no_signal_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized bench for seg7_scan_decoder. A dwell-level model
// decides which patterns settle and what frames/errors must appear.
module tb_seg7_scan_decoder;
  localparam int SYNC    = 2;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 2000;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus();
  logic [1:0] dbg_state;

  seg7_scan_decoder #(
    .SYNC_STAGES(SYNC),
    .SETTLE_CYC (SETTLE),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // seg_n (active-low) patterns for digits 0..9
  logic [6:0] digit_segn [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [3:0] AN_U  = 4'b1110;
  localparam logic [3:0] AN_D  = 4'b1101;
  localparam logic [3:0] AN_NO = 4'b1111;

  int checks = 0;
  int errors = 0;

  // Scoreboard
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];
  logic [14:0] last_exp = '0;
  int          m_errs   = 0;
  int          err_seen = 0;

  // Reference model state
  bit          m_flag_u = 0;
  bit          m_flag_d = 0;
  int          m_u = 0;
  int          m_d = 0;
  logic [10:0] cur_pat  = {AN_NO, BLANK};
  int          cur_len  = 0;
  bit          cur_done = 1;

  // Monitor: collect frames and error strobes
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_valid) got_q.push_back({bus.digit_d, bus.digit_u, bus.value});
      if (bus.seg_err) err_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One settled capture applied to the slot model
  task automatic model_capture(input logic [3:0] an, input logic [6:0] segn);
    bit tens;
    bit legal;
    int dig;
    if (an[3:2] != 2'b11 || an[1] == an[0]) return;
    tens  = (an[1] == 1'b0);
    legal = (segn == BLANK);
    dig   = 0;
    for (int i = 0; i < 10; i++) begin
      if (segn == digit_segn[i]) begin
        legal = 1;
        dig   = i;
      end
    end
    if (!legal) begin
      m_errs++;
      m_flag_u = 0;
      m_flag_d = 0;
      return;
    end
    if (tens) begin m_d = dig; m_flag_d = 1; end
    else      begin m_u = dig; m_flag_u = 1; end
    if (m_flag_u && m_flag_d) begin
      last_exp = {4'(m_d), 4'(m_u), 7'(m_d * 10 + m_u)};
      exp_q.push_back(last_exp);
      m_flag_u = 0;
      m_flag_d = 0;
    end
  endtask

  // Driver: hold a pattern for len cycles; a pattern counts once it has
  // been present for SETTLE consecutive cycles.
  task automatic dwell(input logic [3:0] an, input logic [6:0] segn, input int len);
    bus.an_n  = an;
    bus.seg_n = segn;
    if ({an, segn} == cur_pat) begin
      cur_len += len;
    end else begin
      cur_pat  = {an, segn};
      cur_len  = len;
      cur_done = 0;
    end
    if (!cur_done && cur_len >= SETTLE) begin
      cur_done = 1;
      model_capture(an, segn);
    end
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic check_phase(input string tag);
    int n;
    dwell(AN_NO, BLANK, SETTLE + SYNC + 4);
    check({tag, ".frames"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ".frame"}, got_q[i], exp_q[i]);
    check({tag, ".seg_err"}, err_seen, m_errs);
    check({tag, ".hold"}, {bus.digit_d, bus.digit_u, bus.value}, last_exp);
    got_q.delete();
    exp_q.delete();
    err_seen = 0;
    m_errs   = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".value"}, bus.value, 0);
    check({tag, ".digits"}, {bus.digit_d, bus.digit_u}, 0);
    check({tag, ".strobes"}, {bus.frame_valid, bus.seg_err, bus.no_signal}, 0);
  endtask

  // Watchdog
  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] an;
    logic [6:0] segn;
    int r;

    // Power-on reset
    bus.an_n  = AN_NO;
    bus.seg_n = BLANK;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Units 5 then tens 1 -> 15
    dwell(AN_U, 7'h12, 20);
    dwell(AN_D, 7'h79, 20);
    check_phase("t2");
    check("t2.value", bus.value, 15);

    // Reset mid-frame discards a pending units capture
    dwell(AN_U, digit_segn[9], 20);
    bus.an_n  = AN_NO;
    bus.seg_n = BLANK;
    #2 rst_n = 1'b0;
    #1;
    check_zero("midreset");
    m_flag_u = 0; m_flag_d = 0;
    cur_pat  = {AN_NO, BLANK};
    cur_done = 1;
    last_exp = '0;
    got_q.delete();
    err_seen = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    dwell(AN_D, digit_segn[2], 20);
    check_phase("t1.one");
    dwell(AN_U, digit_segn[4], 20);
    check_phase("t1.two");

    // Settle boundary: SETTLE-1 tens dwells ignored, SETTLE captured
    dwell(AN_U, digit_segn[6], SETTLE);
    dwell(AN_D, digit_segn[2], SETTLE - 1);
    dwell(AN_U, digit_segn[6], SETTLE);
    dwell(AN_D, digit_segn[2], SETTLE - 1);
    dwell(AN_U, digit_segn[6], SETTLE);
    check_phase("t3.short");
    dwell(AN_D, digit_segn[2], SETTLE);
    check_phase("t3.exact");

    // Illegal pattern clears both slots
    dwell(AN_D, digit_segn[4], 20);
    dwell(AN_U, 7'h36, 20);
    dwell(AN_U, digit_segn[3], 20);
    check_phase("t4.err");
    dwell(AN_D, digit_segn[4], 20);
    check_phase("t4.recover");

    // Blank tens, ignored enables, units 7 -> 07
    dwell(AN_D, BLANK, 20);
    dwell(4'b1011, 7'(($urandom_range(0, 127))), 20);
    dwell(4'b0111, digit_segn[3], 20);
    dwell(4'b1100, digit_segn[1], 20);
    dwell(AN_U, 7'h78, 20);
    check_phase("t5");
    check("t5.digits", {bus.digit_d, bus.digit_u}, 8'h07);

    // Randomized dwells
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 20; k++) begin
        r = $urandom_range(0, 15);
        if (r < 6)       an = AN_U;
        else if (r < 12) an = AN_D;
        else if (r == 12) an = 4'b1011;
        else if (r == 13) an = 4'b0111;
        else if (r == 14) an = 4'b1100;
        else             an = AN_NO;
        r = $urandom_range(0, 11);
        if (r < 10)      segn = digit_segn[r];
        else if (r == 10) segn = BLANK;
        else             segn = 7'($urandom_range(0, 127));
        dwell(an, segn, $urandom_range(SETTLE - 2, SETTLE + 8));
      end
      check_phase("rand");
    end

    // Timeout: silence after a units capture
    dwell(AN_U, digit_segn[5], SETTLE);
    dwell(AN_NO, BLANK, TIMEOUT - 10);
    check("t6.before", bus.no_signal, 0);
    dwell(AN_NO, BLANK, 30);
    check("t6.expired", bus.no_signal, 1);
    m_flag_u = 0;
    m_flag_d = 0;
    check("t6.hold", {bus.digit_d, bus.digit_u, bus.value}, last_exp);
    dwell(AN_U, digit_segn[5], SETTLE);
    check("t6.cap", bus.no_signal, 1);
    dwell(AN_U, digit_segn[5], SYNC - 1);
    check("t6.late", bus.no_signal, 1);
    dwell(AN_U, digit_segn[5], 1);
    check("t6.clear", bus.no_signal, 0);
    dwell(AN_D, digit_segn[0], 20);
    check_phase("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
